// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; a bounded starvation guard lets a waiting fetch through.
module mem_arbiter #(
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        busy,
    output logic        err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            err_q;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_store;
    logic            lat_wr;

    logic dreq;
    logic in_acc;
    logic own_req;
    logic done;
    logic abort;
    logic tmo_hit;
    logic arb;
    logic arb_d;
    logic arb_i;
    logic grant_d;
    logic grant_i;

    assign dreq    = dREN | dWEN;
    assign in_acc  = (state != IDLE);
    assign own_req = ((state == DACC) & dreq) | ((state == IACC) & iREN);
    assign done    = in_acc & own_req & ram_ready;
    assign abort   = in_acc & ~own_req;
    assign tmo_hit = in_acc & own_req & ~ram_ready & (tmo_cnt == TMO_LAST);

    // The requester completing this cycle still holds its request; mask it so
    // the same access is not granted twice.
    assign arb     = (state == IDLE) | done;
    assign arb_d   = dreq & ~(done & (state == DACC));
    assign arb_i   = iREN & ~(done & (state == IACC));
    assign grant_d = arb & arb_d & (~arb_i | (starve_cnt < STARVE_LIM));
    assign grant_i = arb & ~grant_d & arb_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (grant_d) begin
            state_nxt = DACC;
        end else if (grant_i) begin
            state_nxt = IACC;
        end else if (arb | abort | tmo_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
            lat_addr   <= '0;
            lat_store  <= '0;
            lat_wr     <= 1'b0;
        end else begin
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d) begin
                if (!arb_i) begin
                    starve_cnt <= '0;
                end else if (starve_cnt < STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            if (grant_d | grant_i) begin
                tmo_cnt <= '0;
            end else if (in_acc & own_req & ~ram_ready & ~tmo_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit) begin
                err_q <= 1'b1;
            end

            if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_wr    <= dWEN;
            end else if (grant_i) begin
                lat_addr  <= iaddr;
                lat_wr    <= 1'b0;
            end
        end
    end

    // Every output is forced low while RST is held, regardless of state.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;
        busy      = 1'b0;
        err       = 1'b0;
        if (!RST) begin
            busy = in_acc;
            err  = err_q;
            unique case (state)
                DACC: begin
                    ram_ren   = ~lat_wr;
                    ram_wen   = lat_wr;
                    ram_addr  = lat_addr;
                    ram_store = lat_store;
                    dhit      = done;
                    dload     = done ? ram_load : '0;
                end
                IACC: begin
                    ram_ren   = 1'b1;
                    ram_addr  = lat_addr;
                    ihit      = done;
                    iload     = done ? ram_load : '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STV = 2;
    localparam int TMO = 4;

    typedef struct packed {
        logic        rst;
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ram_load;
        logic        rdy;
    } in_t;

    typedef struct packed {
        logic        ihit;
        logic        dhit;
        logic [31:0] iload;
        logic [31:0] dload;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic        busy;
        logic        err;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        ihit;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dhit;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load;
    logic        ram_ready;
    logic        busy;
    logic        err;

    mem_arbiter #(.STARVE_MAX(STV), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .busy(busy), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    out_t got;
    assign got = {ihit, dhit, iload, dload, ram_ren, ram_wen, ram_addr, ram_store, busy, err};

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: who owns the RAM, how long it has waited, how many data
    // grants have overtaken a waiting fetch, and what the grant captured.
    int          owner;
    int          waited;
    int          streak;
    bit          sticky;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    bit          m_wr;
    out_t        m_exp;

    task automatic model_cycle(input in_t x, output out_t e);
        bit dreq, own_req, done, di, ii;
        e = '0;
        if (x.rst) begin
            owner = 0; waited = 0; streak = 0; sticky = 0;
            m_addr = 0; m_store = 0; m_wr = 0;
        end else begin
            dreq    = x.dren | x.dwen;
            own_req = (owner == 1) ? dreq : (owner == 2) ? x.iren : 1'b0;
            done    = (owner != 0) && own_req && x.rdy;
            e.busy  = (owner != 0);
            e.err   = sticky;
            if (owner == 1) begin
                e.wen = m_wr; e.ren = !m_wr; e.addr = m_addr; e.store = m_store;
                if (done) begin e.dhit = 1; e.dload = x.ram_load; end
            end else if (owner == 2) begin
                e.ren = 1; e.addr = m_addr;
                if (done) begin e.ihit = 1; e.iload = x.ram_load; end
            end
            if (owner == 0 || done) begin
                di = dreq && !(done && owner == 1);
                ii = x.iren && !(done && owner == 2);
                if (di && (!ii || streak < STV)) begin
                    streak  = ii ? streak + 1 : 0;
                    owner   = 1; waited = 0;
                    m_addr  = x.daddr; m_store = x.dstore; m_wr = x.dwen;
                end else if (ii) begin
                    streak = 0; owner = 2; waited = 0;
                    m_addr = x.iaddr; m_wr = 0;
                end else begin
                    owner = 0;
                end
            end else if (!own_req) begin
                owner = 0;
            end else begin
                waited++;
                if (waited == TMO) begin
                    owner = 0; sticky = 1;
                end
            end
        end
    endtask

    task automatic cyc(input in_t x);
        @(posedge CLK);
        #1;
        RST = x.rst; iREN = x.iren; iaddr = x.iaddr;
        dREN = x.dren; dWEN = x.dwen; daddr = x.daddr; dstore = x.dstore;
        ram_load = x.ram_load; ram_ready = x.rdy;
        #4;
        model_cycle(x, m_exp);
    endtask

    task automatic cmp(input string nm, input out_t g, input out_t e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, g, e);
        end
    endtask

    function automatic in_t mi(logic rst, logic iren, logic [31:0] ia, logic dren, logic dwen,
                               logic [31:0] da, logic [31:0] ds, logic [31:0] ld, logic rdy);
        return {rst, iren, ia, dren, dwen, da, ds, ld, rdy};
    endfunction

    function automatic out_t mo(logic ih, logic dh, logic [31:0] il, logic [31:0] dl, logic ren,
                                logic wen, logic [31:0] a, logic [31:0] s, logic b, logic e);
        return {ih, dh, il, dl, ren, wen, a, s, b, e};
    endfunction

    vec_t tv [17];
    out_t zero_o;
    out_t acc_o;
    in_t  x;
    bit   ion, don;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ram_load = 0; ram_ready = 0;
        zero_o = '0;

        // reset, fetch with 2-cycle RAM latency, data-before-fetch, write precedence
        tv[0]  = '{mi(1, 1, 32'h40, 1, 0, 32'h100, 0, 32'h1, 1), zero_o};
        tv[1]  = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tv[2]  = '{mi(0, 1, 32'h40, 0, 0, 0, 0, 0, 0), zero_o};
        tv[3]  = '{mi(0, 1, 32'h40, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 32'h40, 0, 1, 0)};
        tv[4]  = '{mi(0, 1, 32'h40, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 32'h40, 0, 1, 0)};
        tv[5]  = '{mi(0, 1, 32'h40, 0, 0, 0, 0, 32'h2402000A, 1),
                   mo(1, 0, 32'h2402000A, 0, 1, 0, 32'h40, 0, 1, 0)};
        tv[6]  = '{mi(0, 0, 0, 0, 0, 0, 0, 32'h2402000A, 1), zero_o};
        tv[7]  = '{mi(0, 1, 32'h44, 1, 0, 32'h100, 0, 0, 0), zero_o};
        tv[8]  = '{mi(0, 1, 32'h44, 1, 0, 32'h100, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 32'h100, 0, 1, 0)};
        tv[9]  = '{mi(0, 1, 32'h44, 1, 0, 32'h100, 0, 32'h11112222, 1),
                   mo(0, 1, 0, 32'h11112222, 1, 0, 32'h100, 0, 1, 0)};
        tv[10] = '{mi(0, 1, 32'h44, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 0)};
        tv[11] = '{mi(0, 1, 32'h44, 0, 0, 0, 0, 32'h33334444, 1),
                   mo(1, 0, 32'h33334444, 0, 1, 0, 32'h44, 0, 1, 0)};
        tv[12] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};
        tv[13] = '{mi(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 0, 0), zero_o};
        tv[14] = '{mi(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 0, 0),
                   mo(0, 0, 0, 0, 0, 1, 32'h80, 32'hDEADBEEF, 1, 0)};
        tv[15] = '{mi(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 0, 1),
                   mo(0, 1, 0, 0, 0, 1, 32'h80, 32'hDEADBEEF, 1, 0)};
        tv[16] = '{mi(0, 0, 0, 0, 0, 0, 0, 0, 0), zero_o};

        for (int k = 0; k < 17; k++) begin
            cyc(tv[k].i);
            cmp($sformatf("tbl[%0d]", k), got, tv[k].o);
        end

        // timeout: four access cycles without ram_ready, then IDLE with sticky err
        cyc(mi(0, 1, 32'h200, 0, 0, 0, 0, 0, 0));
        cmp("tmo_grant", got, zero_o);
        acc_o = mo(0, 0, 0, 0, 1, 0, 32'h200, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(mi(0, 1, 32'h200, 0, 0, 0, 0, 0, 0));
            cmp($sformatf("tmo_wait[%0d]", k), got, acc_o);
        end
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 32'h9, 1));
        cmp("tmo_idle", got, mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
        cmp("tmo_sticky", got, mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

        // reset in the middle of a fetch: abandoned, err cleared, no late hit
        cyc(mi(0, 1, 32'h300, 0, 0, 0, 0, 0, 0));
        cmp("rst_grant", got, mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(mi(0, 1, 32'h300, 0, 0, 0, 0, 0, 0));
        cmp("rst_iacc", got, mo(0, 0, 0, 0, 1, 0, 32'h300, 0, 1, 1));
        cyc(mi(1, 1, 32'h300, 0, 0, 0, 0, 32'h77, 1));
        cmp("rst_held", got, zero_o);
        cyc(mi(0, 0, 0, 0, 0, 0, 0, 32'h77, 1));
        cmp("rst_after", got, zero_o);

        // starvation guard: two aborted data grants while fetch waits, then fetch wins
        cyc(mi(0, 1, 32'h400, 1, 0, 32'h500, 0, 0, 0));
        cmp("stv_d1_grant", got, zero_o);
        cyc(mi(0, 1, 32'h400, 0, 0, 32'h500, 0, 0, 0));
        cmp("stv_d1_abort", got, mo(0, 0, 0, 0, 1, 0, 32'h500, 0, 1, 0));
        cyc(mi(0, 1, 32'h400, 1, 0, 32'h500, 0, 0, 0));
        cmp("stv_d2_grant", got, zero_o);
        cyc(mi(0, 1, 32'h400, 0, 0, 32'h500, 0, 0, 0));
        cmp("stv_d2_abort", got, mo(0, 0, 0, 0, 1, 0, 32'h500, 0, 1, 0));
        cyc(mi(0, 1, 32'h400, 1, 0, 32'h500, 0, 0, 0));
        cmp("stv_i_grant", got, zero_o);
        cyc(mi(0, 1, 32'h400, 1, 0, 32'h500, 0, 32'hA5A5, 1));
        cmp("stv_i_hit", got, mo(1, 0, 32'hA5A5, 0, 1, 0, 32'h400, 0, 1, 0));
        cyc(mi(0, 1, 32'h400, 1, 0, 32'h500, 0, 32'h5A5A, 1));
        cmp("stv_d_b2b", got, mo(0, 1, 0, 32'h5A5A, 1, 0, 32'h500, 0, 1, 0));
        cyc(mi(0, 1, 32'h400, 0, 0, 0, 0, 0, 0));
        cmp("stv_i_b2b", got, mo(0, 0, 0, 0, 1, 0, 32'h400, 0, 1, 0));

        // randomized traffic against the reference model
        ion = 0;
        don = 0;
        cyc(mi(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cmp("rnd_reset", got, m_exp);
        for (int k = 0; k < 3000; k++) begin
            ion = ion ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            don = don ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 4);
            x.rst      = ($urandom_range(0, 199) == 0);
            x.iren     = ion;
            x.iaddr    = $urandom;
            x.dwen     = don & ($urandom_range(0, 2) != 0);
            x.dren     = don & (!x.dwen | ($urandom_range(0, 1) == 1));
            x.daddr    = $urandom;
            x.dstore   = $urandom;
            x.ram_load = $urandom;
            x.rdy      = ($urandom_range(0, 2) == 0);
            cyc(x);
            cmp($sformatf("rnd[%0d]", k), got, m_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
